// File: rtl/clock_1hz_pkg.sv
// -----------------------------------------------------------------------------
// clock_1hz_pkg
// Shared constants and elaboration helpers for the clock_1hz_gen divider.
//   SYS_CLK_FREQ_HZ     : default board clock frequency (100 MHz)
//   DEFAULT_OUT_FREQ_HZ : default divided output frequency (1 Hz)
//   half_count()        : clk cycles per output half-period (truncating)
//   cnt_width()         : bits needed to count 0 .. n-1, minimum 1
// -----------------------------------------------------------------------------
package clock_1hz_pkg;

    localparam int SYS_CLK_FREQ_HZ     = 100_000_000;
    localparam int DEFAULT_OUT_FREQ_HZ = 1;

    // Truncating division: an inexact ratio runs slightly fast rather than slow.
    function automatic int half_count(input int clk_hz, input int out_hz);
        return clk_hz / (2 * out_hz);
    endfunction

    // A divide-by-1 counter still needs one bit so the port is never zero-width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_1hz_gen_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Free-running modulo-MOD counter: 0, 1, ..., MOD-1, 0, ...
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears cnt to 0
//   cnt   : current count, W bits
//   wrap  : combinational, high while cnt == MOD-1 (next edge returns to 0)
// -----------------------------------------------------------------------------
module mod_counter
    import clock_1hz_pkg::*;
#(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Explicit compare-and-clear so non-power-of-two moduli never overrun.
    assign wrap = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the async reset is in the sensitivity list so it acts
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/clock_1hz_gen.sv
// -----------------------------------------------------------------------------
// clock_1hz_gen
// Divides the system clock down to a 50 % duty square wave. The output is a
// registered logic signal for slow timebase use, not a clock-tree net.
// Parameters:
//   CLK_FREQ_HZ : input clock frequency   (default 100_000_000)
//   OUT_FREQ_HZ : output frequency        (default 1)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   nclk  : divided square wave, registered; first rise on the HALF_CNT-th
//           clk edge after reset release
//   tick  : one-cycle strobe in the cycle nclk goes 0->1
//           (present only when CLOCK_1HZ_TICK_EN is defined)
// Build option:
//   CLOCK_1HZ_TICK_EN : adds the tick port and its flop
// -----------------------------------------------------------------------------
module clock_1hz_gen
    import clock_1hz_pkg::*;
#(
    parameter int CLK_FREQ_HZ = SYS_CLK_FREQ_HZ,
    parameter int OUT_FREQ_HZ = DEFAULT_OUT_FREQ_HZ
) (
    input  logic clk,
    input  logic rst_n,
`ifdef CLOCK_1HZ_TICK_EN
    output logic tick,
`endif
    output logic nclk
);

    localparam int HALF_CNT = half_count(CLK_FREQ_HZ, OUT_FREQ_HZ);
    localparam int CNT_W    = cnt_width(HALF_CNT);

    generate
        if (2 * OUT_FREQ_HZ > CLK_FREQ_HZ) begin : g_bad_ratio
            $error("clock_1hz_gen: OUT_FREQ_HZ must be at most CLK_FREQ_HZ/2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    mod_counter #(
        .MOD (HALF_CNT),
        .W   (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // The counter must stay within one half-period.
    always_comb begin : a_cnt_range
        assert (cnt <= CNT_W'(HALF_CNT - 1));
    end

    // One toggle per half-period gives exactly HALF_CNT cycles high, HALF_CNT low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nclk <= 1'b0;
        end else if (wrap) begin
            nclk <= ~nclk;
        end
    end

`ifdef CLOCK_1HZ_TICK_EN
    // wrap while nclk is low is exactly the edge where nclk rises, so tick
    // lands in the same cycle nclk first reads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap & ~nclk;
        end
    end
`endif

endmodule

// File: tb/tb_clock_1hz_gen.sv
`timescale 1ns/1ps
module tb_clock_1hz_gen;

    typedef struct {
        int   edge_n;
        logic level;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic nclk_a, nclk_b, nclk_c;
    logic tick_a, tick_b, tick_c;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rel_cyc = 0;

    ev_t qa[$];
    ev_t qb[$];
    ev_t qc[$];
    int  qt[$];

    logic pa = 1'b0;
    logic pb = 1'b0;
    logic pc = 1'b0;

    // HALF_CNT = 10, 1 and 12 respectively
    clock_1hz_gen #(.CLK_FREQ_HZ(20), .OUT_FREQ_HZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef CLOCK_1HZ_TICK_EN
        .tick(tick_a),
`endif
        .nclk(nclk_a));
    clock_1hz_gen #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef CLOCK_1HZ_TICK_EN
        .tick(tick_b),
`endif
        .nclk(nclk_b));
    clock_1hz_gen #(.CLK_FREQ_HZ(25), .OUT_FREQ_HZ(1)) dut_c (
        .clk(clk), .rst_n(rst_n),
`ifdef CLOCK_1HZ_TICK_EN
        .tick(tick_c),
`endif
        .nclk(nclk_c));

`ifndef CLOCK_1HZ_TICK_EN
    assign tick_a = 1'b0;
    assign tick_b = 1'b0;
    assign tick_c = 1'b0;
`endif

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - rel_cyc);
        end
    endtask

    // Expected output transitions for n_cycles edges after a release.
    task automatic push_all(input int n_cycles);
        ev_t e;
        for (int k = 1; k * 10 <= n_cycles; k++) begin
            e.edge_n = k * 10;
            e.level  = (k % 2 == 1);
            qa.push_back(e);
            if (k % 2 == 1) qt.push_back(k * 10);
        end
        for (int k = 1; k <= n_cycles; k++) begin
            e.edge_n = k;
            e.level  = (k % 2 == 1);
            qb.push_back(e);
        end
        for (int k = 1; k * 12 <= n_cycles; k++) begin
            e.edge_n = k * 12;
            e.level  = (k % 2 == 1);
            qc.push_back(e);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_nclk_a"}, int'(nclk_a), 0);
        check({tag, "_nclk_b"}, int'(nclk_b), 0);
        check({tag, "_nclk_c"}, int'(nclk_c), 0);
        check({tag, "_cnt_a"}, int'(dut_a.u_cnt.cnt), 0);
        check({tag, "_tick_a"}, int'(tick_a), 0);
    endtask

    // Assert reset between clock edges, confirm it clears without an edge,
    // then hold for n cycles and release on a falling edge.
    task automatic do_reset(input int n);
        #1 rst_n = 1'b0;
        #1 check_reset_state("rst_async");
        repeat (n) begin
            @(negedge clk);
            check_reset_state("rst_hold");
        end
        rel_cyc = cyc;
        rst_n = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        #1;
        check({tag, "_qa_left"}, qa.size(), 0);
        check({tag, "_qb_left"}, qb.size(), 0);
        check({tag, "_qc_left"}, qc.size(), 0);
`ifdef CLOCK_1HZ_TICK_EN
        check({tag, "_qt_left"}, qt.size(), 0);
`endif
        qa.delete(); qb.delete(); qc.delete(); qt.delete();
    endtask

    // Monitors: pop an expectation whenever an nclk transition is observed.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            pa = 1'b0;
        end else if (nclk_a !== pa) begin
            if (qa.size() == 0) check("a_unexpected_edge", cyc - rel_cyc, -1);
            else begin
                e = qa.pop_front();
                check("a_edge_cycle", cyc - rel_cyc, e.edge_n);
                check("a_edge_level", int'(nclk_a), int'(e.level));
            end
            pa = nclk_a;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            pb = 1'b0;
        end else if (nclk_b !== pb) begin
            if (qb.size() == 0) check("b_unexpected_edge", cyc - rel_cyc, -1);
            else begin
                e = qb.pop_front();
                check("b_edge_cycle", cyc - rel_cyc, e.edge_n);
                check("b_edge_level", int'(nclk_b), int'(e.level));
            end
            pb = nclk_b;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            pc = 1'b0;
        end else begin
            check("c_cnt_over_11", int'(dut_c.u_cnt.cnt > 11), 0);
            if (nclk_c !== pc) begin
                if (qc.size() == 0) check("c_unexpected_edge", cyc - rel_cyc, -1);
                else begin
                    e = qc.pop_front();
                    check("c_edge_cycle", cyc - rel_cyc, e.edge_n);
                    check("c_edge_level", int'(nclk_c), int'(e.level));
                end
                pc = nclk_c;
            end
        end
    end

`ifdef CLOCK_1HZ_TICK_EN
    always @(negedge clk) begin
        if (rst_n && tick_a === 1'b1) begin
            if (qt.size() == 0) check("tick_unexpected", cyc - rel_cyc, -1);
            else check("tick_cycle", cyc - rel_cyc, qt.pop_front());
            check("tick_with_nclk_high", int'(nclk_a), 1);
        end
    end
`endif

    initial begin
        // Reset held 3 cycles, then 200 cycles of free running.
        do_reset(3);
        push_all(200);
        repeat (200) @(negedge clk);
        check_drained("run200");

        // Reset mid-operation at cycle 15 while nclk_a is high.
        do_reset(2);
        push_all(15);
        repeat (15) @(negedge clk);
        check_drained("pre_midrst");
        check("a_high_at_15", int'(nclk_a), 1);
        do_reset(2);

        // Recovery: first rise 10 edges after release.
        push_all(25);
        repeat (25) @(negedge clk);
        check_drained("post_midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
